// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states, default latencies and op-class decoders for the HI/LO unit.
// The MULDIV_MADD_EN macro enables the accumulate ops (MADD/MADDU/MSUB/MSUBU).
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc_op(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op) || is_acc_op(op);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational multiply/divide datapath producing the full {HI,LO} result for an op.
// With MULDIV_MADD_EN defined, also builds the accumulate adder fed from the current HI/LO.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULDIV_MADD_EN
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
`endif
    output logic [2*WIDTH-1:0] result
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    prod_s_s;
    logic [W2-1:0]    prod_u_s;
    logic [WIDTH-1:0] quo_s_s;
    logic [WIDTH-1:0] rem_s_s;
    logic [WIDTH-1:0] quo_u_s;
    logic [WIDTH-1:0] rem_u_s;

    // Low 2*WIDTH bits of a product of extended operands equal the exact product.
    assign prod_s_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Division truncates toward zero; a zero divisor yields HI=a, LO=all ones.
    always_comb begin
        if (b == {WIDTH{1'b0}}) begin
            quo_s_s = {WIDTH{1'b1}};
            rem_s_s = a;
            quo_u_s = {WIDTH{1'b1}};
            rem_u_s = a;
        end else begin
            quo_s_s = $signed(a) / $signed(b);
            rem_s_s = $signed(a) % $signed(b);
            quo_u_s = a / b;
            rem_u_s = a % b;
        end
    end

`ifdef MULDIV_MADD_EN
    logic [W2-1:0] acc_s;
    assign acc_s = {hi, lo};
`endif

    // Result select by op class.
    always_comb begin
        result = {W2{1'b0}};
        case (op)
            OP_MULT:  result = prod_s_s;
            OP_MULTU: result = prod_u_s;
            OP_DIV:   result = {rem_s_s, quo_s_s};
            OP_DIVU:  result = {rem_u_s, quo_u_s};
`ifdef MULDIV_MADD_EN
            OP_MADD:  result = acc_s + prod_s_s;
            OP_MADDU: result = acc_s + prod_u_s;
            OP_MSUB:  result = acc_s - prod_s_s;
            OP_MSUBU: result = acc_s - prod_u_s;
`endif
            default:  result = {W2{1'b0}};
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: IDLE/BUSY control, latency counter, shadow result and HI/LO registers.
// The HI/LO-use input is named use_hilo because "use" is a reserved word. Option: MULDIV_MADD_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] core_result_s;
    logic               accept_s;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MULDIV_MADD_EN
        .hi     (hi_q),
        .lo     (lo_q),
`endif
        .result (core_result_s)
    );

    assign accept_s = start & ~flush & (state_q == ST_IDLE);

    // Next-state: launch, countdown, completion and flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_op(op) || is_acc_op(op)) begin
                        shadow_d = core_result_s;
                        cnt_d    = MUL_LOAD;
                        state_d  = ST_BUSY;
                    end else if (is_div_op(op)) begin
                        shadow_d = core_result_s;
                        cnt_d    = DIV_LOAD;
                        state_d  = ST_BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end else begin
                    state_d = ST_IDLE;
                    hi_d    = shadow_q[2*WIDTH-1:WIDTH];
                    lo_d    = shadow_q[WIDTH-1:0];
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            shadow_q <= {(2*WIDTH){1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = use_hilo & (busy | (start & is_long_op(op)));

    // Move-from read port.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        case (op)
            OP_MFHI: rdata = hi_q;
            OP_MFLO: rdata = lo_q;
            default: rdata = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model checked every cycle plus literal expectations.
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        use_hilo = 1'b0;
    logic        flush = 1'b0;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo, rdata;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = 64'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .use_hilo(use_hilo), .flush(flush), .busy(busy), .stall_req(stall_req),
        .done(done), .hi(hi), .lo(lo), .rdata(rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit long_op(input logic [3:0] o);
        if (o >= 4'd1 && o <= 4'd4) return 1'b1;
`ifdef MULDIV_MADD_EN
        if (o >= 4'd9 && o <= 4'd12) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] h, input logic [31:0] l);
        longint          sx, sy;
        longint unsigned ux, uy;
        int              si, sj;
        logic [63:0]     acc;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        si  = x;
        sj  = y;
        acc = {h, l};
        case (o)
            4'd1:  return sx * sy;
            4'd2:  return ux * uy;
            4'd3:  return (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {32'(si % sj), 32'(si / sj)};
            4'd4:  return (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            4'd9:  return acc + 64'(sx * sy);
            4'd10: return acc + 64'(ux * uy);
            4'd11: return acc - 64'(sx * sy);
            4'd12: return acc - 64'(ux * uy);
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_res = 64'd0; m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic f);
        m_done = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (m_busy) begin
            if (f) begin
                m_busy = 1'b0;
                m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end
        end else if (s && !f) begin
            if (long_op(o)) begin
                m_res  = calc(o, x, y, m_hi, m_lo);
                m_busy = 1'b1;
                m_left = (o == 4'd3 || o == 4'd4) ? DC : MC;
            end else if (o == 4'd5) begin
                m_hi = x;
            end else if (o == 4'd6) begin
                m_lo = x;
            end
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
    task automatic cyc(input logic s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic u, input logic f);
        start = s; op = o; a = x; b = y; use_hilo = u; flush = f;
        @(posedge clk);
        model_edge(s, o, x, y, f);
        #1;
    endtask

    task automatic run_until_done(input string name, input int budget, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (busy) nbusy++;
            cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            if (done) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("stall_req", 64'(stall_req), 64'(use_hilo & (m_busy | (start & long_op(op)))));
            check("rdata", 64'(rdata), 64'((op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        bit  seen;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;

        // MULT -3 * 7
        cyc(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
        run_until_done("mult", 20, nb);
        check("mult_busy_cycles", 64'(nb), 64'd5);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("mult_done_one_cycle", 64'(done), 64'd0);

        // DIVU 100 / 7
        cyc(1'b1, 4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
        run_until_done("divu", 30, nb);
        check("divu_busy_cycles", 64'(nb), 64'd10);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        // DIV -7 / 2
        cyc(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_until_done("div", 30, nb);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // DIV by zero, MTHI attempted while busy
        cyc(1'b1, 4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_until_done("div0", 30, nb);
        check("div0_hi", 64'(hi), 64'd5);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);

        // MULTU max * max
        cyc(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_until_done("multu", 20, nb);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);

        // MTHI/MTLO and the read port
        cyc(1'b1, 4'd5, 32'd1, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 32'd2, 32'd0, 1'b0, 1'b0);
        check("mt_busy", 64'(busy), 64'd0);
        check("mthi", 64'(hi), 64'd1);
        check("mtlo", 64'(lo), 64'd2);
        start = 1'b0; op = 4'd7; #1;
        check("mfhi_rdata", 64'(rdata), 64'd1);
        op = 4'd8; #1;
        check("mflo_rdata", 64'(rdata), 64'd2);
        op = 4'd0;

        // MULT flushed on the third busy cycle
        cyc(1'b1, 4'd1, 32'd4, 32'd4, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'd1);
        check("flush_lo", 64'(lo), 64'd2);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            if (done) seen = 1'b1;
        end
        check("flush_no_done", 64'(seen), 64'd0);

        // start together with flush is dropped
        cyc(1'b1, 4'd1, 32'd3, 32'd3, 1'b0, 1'b1);
        check("flush_start_dropped", 64'(busy), 64'd0);

        // Accumulate
        cyc(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 32'h10, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd9, 32'd3, 32'd4, 1'b1, 1'b0);
`ifdef MULDIV_MADD_EN
        run_until_done("madd", 20, nb);
        check("madd_busy_cycles", 64'(nb), 64'd5);
        check("madd_lo", 64'(lo), 64'h1C);
        check("madd_hi", 64'(hi), 64'd0);
        cyc(1'b1, 4'd11, 32'd1, 32'd1, 1'b0, 1'b0);
        run_until_done("msub", 20, nb);
        check("msub_lo", 64'(lo), 64'h1B);
        cyc(1'b1, 4'd12, 32'd2, 32'h10, 1'b0, 1'b0);
        run_until_done("msubu", 20, nb);
        check("msubu_hi", 64'(hi), 64'hFFFF_FFFF);
        check("msubu_lo", 64'(lo), 64'hFFFF_FFFB);
`else
        seen = busy;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            if (busy) seen = 1'b1;
        end
        check("madd_off_busy", 64'(seen), 64'd0);
        check("madd_off_lo", 64'(lo), 64'h10);
        check("madd_off_hi", 64'(hi), 64'd0);
`endif

        // Reset asserted during the second busy cycle of DIV
        cyc(1'b1, 4'd6, 32'h55, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd3, 32'd100, 32'd3, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        model_reset();
        use_hilo = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_stall", 64'(stall_req), 64'd0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 4'd6, 32'd7, 32'd0, 1'b0, 1'b0);
        check("first_accept_after_reset", 64'(lo), 64'd7);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
